rtc_init_sequencer: RTL

- Parametrised power-up/re-init sequencer for the RTC parallel bus.
- Walks a table of NUM_ENTRIES {address, data, kind} entries and holds each on the bus for HOLD_CYCLES clocks.
- Yields the bus while the write, read or chronometer masters are active, and resumes without losing its position.
- Sits beside the write/read/crono controllers and feeds the shared address/data mux through an output-enable, not tri-states.

---
 rtl/rtc_init_pkg.sv | 52 +++++
 rtl/init_hold_timer.sv | 39 +++
 rtl/rtc_init_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_init_pkg.sv
// -----------------------------------------------------------------------------
// rtc_init_pkg
// Shared types for the RTC bus init sequencer: table entry layout, entry kind,
// sequencer states and the built-in default init table.
// Table entries are stored at a fixed 8-bit width; the top module resizes them
// to its ADDR_W / DATA_W ports.
// -----------------------------------------------------------------------------
package rtc_init_pkg;

    localparam int TBL_W   = 8;    // width of stored table address/data
    localparam int STEP_W  = 5;    // entry index width (up to 32 entries)
    localparam int TIMER_W = 12;   // hold/gap timer width (up to 4095)

    typedef enum logic {
        K_WRITE = 1'b0,            // address + data write
        K_ADDR  = 1'b1             // address-only strobe
    } kind_e;

    typedef struct packed {
        logic [TBL_W-1:0] addr;
        logic [TBL_W-1:0] data;
        kind_e            kind;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        GAP,
        VERIFY,
        DONE
    } state_e;

    // Default power-up table. Indices past the table return a harmless
    // address-only entry at address 0.
    function automatic entry_t init_entry(input logic [STEP_W-1:0] idx);
        entry_t e;
        e = '{addr: 8'h00, data: 8'h00, kind: K_ADDR};
        case (idx)
            5'd0:  e = '{addr: 8'h02, data: 8'h08, kind: K_WRITE};
            5'd1:  e = '{addr: 8'h02, data: 8'h00, kind: K_WRITE};
            5'd2:  e = '{addr: 8'h21, data: 8'h00, kind: K_WRITE};
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9:
                e.addr = 8'h22 + 8'(idx - 5'd3);
            5'd10: e.addr = 8'h31;
            5'd11: e.addr = 8'h32;
            5'd12: e.addr = 8'h33;
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/init_hold_timer.sv
// -----------------------------------------------------------------------------
// init_hold_timer
// Clear/enable counter with a terminal-count flag, shared by the sequencer's
// HOLD, GAP and VERIFY phases. Holding en low freezes the count.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   clear  in   synchronous return to zero (wins over en)
//   en     in   increment this clock
//   last   in   terminal value for the current phase
//   tc     out  count equals last
// -----------------------------------------------------------------------------
module init_hold_timer
    import rtc_init_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/rtc_init_sequencer.sv
// -----------------------------------------------------------------------------
// rtc_init_sequencer
// Power-up / re-init sequencer for the RTC parallel bus. Walks the default
// init table, presenting each entry for HOLD_CYCLES clocks followed by
// GAP_CYCLES idle clocks. It yields the bus whenever the write, read or
// chronometer master is busy and resumes the same entry at the frozen count.
// Drives the shared address/data mux through oe rather than tri-states.
//
// Configuration macro: INIT_READBACK_EN
//   defined   - each write entry is followed by a VERIFY phase (address only,
//               oe high) whose last clock compares rd_data with the table data;
//               mismatches set the sticky err flag.
//   undefined - no VERIFY phase, rd_data ignored, err tied low.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset, clears all state
//   start     in   level run request; rising edge arms, low aborts
//   escribe   in   write master busy
//   lee       in   read master busy
//   crono     in   chronometer master busy
//   rd_data   in   bus read data (readback only)
//   address   out  entry address
//   data_out  out  entry data (0 for address-only entries)
//   oe        out  sequencer owns the bus this cycle
//   wr        out  entry is a data write
//   busy      out  sequence in progress
//   done      out  sequence complete, sticky until start low
//   step      out  current entry index
//   err       out  readback mismatch seen
// -----------------------------------------------------------------------------
module rtc_init_sequencer
    import rtc_init_pkg::*;
#(
    parameter int NUM_ENTRIES = 13,
    parameter int HOLD_CYCLES = 75,
    parameter int GAP_CYCLES  = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              escribe,
    input  logic              lee,
    input  logic              crono,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              oe,
    output logic              wr,
    output logic              busy,
    output logic              done,
    output logic [4:0]        step,
    output logic              err
);

    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(NUM_ENTRIES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? TIMER_W'(GAP_CYCLES - 1) : '0;
    localparam bit                 HAS_GAP   = (GAP_CYCLES > 0);

    state_e             state;
    state_e             fin_state;
    state_e             adv_state;
    logic               start_q;
    logic               rise;
    logic               bus_yield;
    logic               in_seq;
    logic               count_ok;
    logic               finish;
    logic               timer_clear;
    logic               timer_en;
    logic               timer_tc;
    logic [TIMER_W-1:0] timer_last;
    entry_t             first_e;
    entry_t             nxt_e;

    assign rise      = start & ~start_q;
    assign bus_yield = escribe | lee | crono;
    assign in_seq    = (state == HOLD) || (state == GAP) || (state == VERIFY);
    assign first_e   = init_entry('0);
    assign nxt_e     = init_entry(step + 5'd1);

    // The timer only advances on clocks where the entry is actually on the
    // bus (oe already high) and nobody else wants it. The clock on which oe
    // comes back after a yield therefore does not count, so the entry gets
    // its remaining clocks in full after resuming.
    always_comb begin
        count_ok   = 1'b0;
        timer_last = HOLD_LAST;
        case (state)
            HOLD:   count_ok = oe && !bus_yield;
            GAP: begin
                count_ok   = !bus_yield;
                timer_last = GAP_LAST;
            end
`ifdef INIT_READBACK_EN
            VERIFY: count_ok = oe && !bus_yield;
`endif
            default: ;
        endcase
    end

    assign finish      = count_ok && timer_tc;
    assign timer_clear = !in_seq || !start || finish;
    assign timer_en    = count_ok && !timer_tc;

    // Where the current phase goes when its timer expires.
    always_comb begin
        adv_state = (step == LAST_STEP) ? DONE : HOLD;
        case (state)
`ifdef INIT_READBACK_EN
            HOLD:    fin_state = wr ? VERIFY : (HAS_GAP ? GAP : adv_state);
            VERIFY:  fin_state = HAS_GAP ? GAP : adv_state;
`else
            HOLD:    fin_state = HAS_GAP ? GAP : adv_state;
`endif
            default: fin_state = adv_state;
        endcase
    end

    init_hold_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(timer_clear),
        .en   (timer_en),
        .last (timer_last),
        .tc   (timer_tc)
    );

`ifdef INIT_READBACK_EN
    entry_t cur_e;
    logic   err_q;
    assign cur_e = init_entry(step);
    assign err   = err_q;
`else
    logic rd_data_unused;
    assign rd_data_unused = ^rd_data;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            step     <= '0;
            address  <= '0;
            data_out <= '0;
            oe       <= 1'b0;
            wr       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef INIT_READBACK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    oe   <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    step <= '0;
                    if (rise) begin
                        state    <= HOLD;
                        busy     <= 1'b1;
                        oe       <= 1'b1;
                        address  <= ADDR_W'(first_e.addr);
                        data_out <= (first_e.kind == K_WRITE) ? DATA_W'(first_e.data) : '0;
                        wr       <= (first_e.kind == K_WRITE);
`ifdef INIT_READBACK_EN
                        err_q    <= 1'b0;
`endif
                    end
                end

                HOLD, GAP, VERIFY: begin
                    if (!start) begin
                        // Abort: drop everything, no partial entry completes.
                        state    <= IDLE;
                        oe       <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        step     <= '0;
                        wr       <= 1'b0;
                        address  <= '0;
                        data_out <= '0;
                    end else if (bus_yield) begin
                        oe <= 1'b0;
                    end else if (finish) begin
`ifdef INIT_READBACK_EN
                        if (state == VERIFY && rd_data != DATA_W'(cur_e.data)) begin
                            err_q <= 1'b1;
                        end
`endif
                        state <= fin_state;
                        case (fin_state)
                            HOLD: begin
                                step     <= step + 5'd1;
                                oe       <= 1'b1;
                                address  <= ADDR_W'(nxt_e.addr);
                                data_out <= (nxt_e.kind == K_WRITE) ? DATA_W'(nxt_e.data) : '0;
                                wr       <= (nxt_e.kind == K_WRITE);
                            end
                            VERIFY: begin
                                oe       <= 1'b1;
                                wr       <= 1'b0;
                                data_out <= '0;
                            end
                            DONE: begin
                                oe   <= 1'b0;
                                busy <= 1'b0;
                                done <= 1'b1;
                            end
                            default: oe <= 1'b0;
                        endcase
                    end else if (state != GAP) begin
                        oe <= 1'b1;
                    end
                end

                DONE: begin
                    oe   <= 1'b0;
                    busy <= 1'b0;
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        step  <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    oe    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
